// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types for the round-robin arbiter output stage
package rr_arb_pkg;

  localparam int unsigned ArbNumIn     = 4;
  localparam int unsigned ArbDataWidth = 32;
  localparam int unsigned ArbIdxWidth  = $clog2(ArbNumIn);

  typedef struct packed {
    logic [ArbIdxWidth-1:0]  idx;
    logic [ArbDataWidth-1:0] data;
    logic                    last;
  } arb_beat_t;

  typedef enum logic {
    LOCK_IDLE,
    LOCK_BURST
  } lock_state_e;

endpackage

// File: rtl/rr_arb_skid_buf.sv
// rtl/rr_arb_skid_buf.sv - two-entry valid/ready skid buffer for arbiter beats
module rr_arb_skid_buf
  import rr_arb_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      in_tvalid,
  output logic      in_tready,
  input  arb_beat_t in_tdata,
  output logic      out_tvalid,
  input  logic      out_tready,
  output arb_beat_t out_tdata
);

  logic      main_valid_q;
  arb_beat_t main_q;
  logic      skid_valid_q;
  arb_beat_t skid_q;
  logic      in_fire;
  logic      out_fire;

  // Ready depends only on skid occupancy, so there is no path from out_tready.
  assign in_tready  = !skid_valid_q;
  assign in_fire    = in_tvalid && in_tready;
  assign out_fire   = main_valid_q && out_tready;
  assign out_tvalid = main_valid_q;
  assign out_tdata  = main_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_valid_q <= 1'b0;
      main_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else if (!main_valid_q || out_fire) begin
      if (skid_valid_q) begin
        main_q       <= skid_q;
        main_valid_q <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (in_fire) begin
        main_q       <= in_tdata;
        main_valid_q <= 1'b1;
      end else begin
        main_valid_q <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q       <= in_tdata;
      skid_valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/rr_arb_out_stage.sv
// rtl/rr_arb_out_stage.sv - registered output stage with burst lock, grant decode and error flag
module rr_arb_out_stage
  import rr_arb_pkg::*;
#(
  parameter int unsigned NumIn     = ArbNumIn,
  parameter int unsigned DataWidth = ArbDataWidth
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_valid_i,
  input  logic [$clog2(NumIn)-1:0]      req_idx_i,
  input  logic [DataWidth-1:0]          req_data_i,
  input  logic                          req_last_i,
  output logic                          req_ready_o,
  output logic                          lock_o,
  output logic [NumIn-1:0]              gnt_o,
  output logic                          out_valid_o,
  output logic [$clog2(NumIn)-1:0]      out_idx_o,
  output logic [DataWidth-1:0]          out_data_o,
  output logic                          out_last_o,
  input  logic                          out_ready_i,
  output logic                          err_o
);

  localparam int unsigned IdxWidth = $clog2(NumIn);

  arb_beat_t             in_beat;
  arb_beat_t             out_beat;
  logic                  accept;
  lock_state_e           state_q, state_d;
  logic [IdxWidth-1:0]   lock_idx_q, lock_idx_d;
  logic                  err_q, err_d;

  assign in_beat = '{idx: req_idx_i, data: req_data_i, last: req_last_i};

  rr_arb_skid_buf u_skid_buf (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_tvalid  (req_valid_i),
    .in_tready  (req_ready_o),
    .in_tdata   (in_beat),
    .out_tvalid (out_valid_o),
    .out_tready (out_ready_i),
    .out_tdata  (out_beat)
  );

  assign out_idx_o  = out_beat.idx;
  assign out_data_o = out_beat.data;
  assign out_last_o = out_beat.last;

  // Reset gates the accept so no grant is pulsed in a cycle that is being flushed.
  assign accept = req_valid_i && req_ready_o && !rst_i;

  always_comb begin
    gnt_o = '0;
    if (accept) gnt_o[req_idx_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= LOCK_IDLE;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    err_d      = err_q;
    if (accept) begin
      case (state_q)
        LOCK_IDLE: begin
          if (!req_last_i) begin
            state_d    = LOCK_BURST;
            lock_idx_d = req_idx_i;
          end
        end
        LOCK_BURST: begin
          if (req_idx_i != lock_idx_q) err_d = 1'b1;
          if (req_last_i) state_d = LOCK_IDLE;
        end
        default: state_d = LOCK_IDLE;
      endcase
    end
  end

  assign lock_o = (state_q == LOCK_BURST);
  assign err_o  = err_q;

endmodule

// File: tb/tb_rr_arb_out_stage.sv
// tb/tb_rr_arb_out_stage.sv - directed table-driven bench for rr_arb_out_stage
module tb_rr_arb_out_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic [1:0]  req_idx_i;
  logic [31:0] req_data_i;
  logic        req_last_i;
  logic        req_ready_o;
  logic        lock_o;
  logic [3:0]  gnt_o;
  logic        out_valid_o;
  logic [1:0]  out_idx_o;
  logic [31:0] out_data_o;
  logic        out_last_o;
  logic        out_ready_i;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  rr_arb_out_stage dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_idx_i   (req_idx_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .lock_o      (lock_o),
    .gnt_o       (gnt_o),
    .out_valid_o (out_valid_o),
    .out_idx_o   (out_idx_o),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .out_ready_i (out_ready_i),
    .err_o       (err_o)
  );

  typedef struct {
    logic        rst;
    logic        v;
    logic [1:0]  idx;
    logic [31:0] data;
    logic        last;
    logic        ordy;
    logic        rdy;
    logic [3:0]  gnt;
    logic        ov;
    logic [1:0]  oidx;
    logic [31:0] odata;
    logic        olast;
    logic        lock;
    logic        err;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(logic rst, logic v, logic [1:0] idx, logic [31:0] data,
                              logic last, logic ordy, logic rdy, logic [3:0] gnt,
                              logic ov, logic [1:0] oidx, logic [31:0] odata,
                              logic olast, logic lock, logic err);
    vec_t r;
    r.rst = rst; r.v = v; r.idx = idx; r.data = data; r.last = last; r.ordy = ordy;
    r.rdy = rdy; r.gnt = gnt; r.ov = ov; r.oidx = oidx; r.odata = odata;
    r.olast = olast; r.lock = lock; r.err = err;
    return r;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d actual=%h expected=%h", name, row, act, exp);
    end
  endtask

  initial begin
    // rows: rst v idx data last ordy | rdy gnt ov oidx odata olast lock err (pre-edge values)
    tbl[0]  = mk(0,0,0,32'h0,0,1,        1,4'b0000,0,0,32'h0,0,0,0);
    tbl[1]  = mk(0,1,2,32'hA5A5_0001,1,1,1,4'b0100,0,0,32'h0,0,0,0);
    tbl[2]  = mk(0,0,0,32'h0,0,1,        1,4'b0000,1,2,32'hA5A5_0001,1,0,0);
    tbl[3]  = mk(0,1,1,32'h11,0,1,       1,4'b0010,0,0,32'h0,0,0,0);
    tbl[4]  = mk(0,1,1,32'h12,0,1,       1,4'b0010,1,1,32'h11,0,1,0);
    tbl[5]  = mk(0,1,1,32'h13,1,1,       1,4'b0010,1,1,32'h12,0,1,0);
    tbl[6]  = mk(0,0,0,32'h0,0,1,        1,4'b0000,1,1,32'h13,1,0,0);
    tbl[7]  = mk(0,1,3,32'h21,1,0,       1,4'b1000,0,0,32'h0,0,0,0);
    tbl[8]  = mk(0,1,3,32'h22,1,0,       1,4'b1000,1,3,32'h21,1,0,0);
    tbl[9]  = mk(0,1,3,32'h23,1,0,       0,4'b0000,1,3,32'h21,1,0,0);
    tbl[10] = mk(0,1,3,32'h23,1,0,       0,4'b0000,1,3,32'h21,1,0,0);
    tbl[11] = mk(0,1,3,32'h23,1,1,       0,4'b0000,1,3,32'h21,1,0,0);
    tbl[12] = mk(0,1,3,32'h23,1,1,       1,4'b1000,1,3,32'h22,1,0,0);
    tbl[13] = mk(0,0,0,32'h0,0,1,        1,4'b0000,1,3,32'h23,1,0,0);
    tbl[14] = mk(0,1,0,32'h31,0,1,       1,4'b0001,0,0,32'h0,0,0,0);
    tbl[15] = mk(0,1,3,32'h32,0,1,       1,4'b1000,1,0,32'h31,0,1,0);
    tbl[16] = mk(0,1,0,32'h33,0,0,       1,4'b0001,1,3,32'h32,0,1,1);
    tbl[17] = mk(0,1,0,32'h34,0,0,       0,4'b0000,1,3,32'h32,0,1,1);
    tbl[18] = mk(1,1,0,32'h34,0,0,       0,4'b0000,1,3,32'h32,0,1,1);
    tbl[19] = mk(0,0,0,32'h0,0,1,        1,4'b0000,0,0,32'h0,0,0,0);
    tbl[20] = mk(1,1,2,32'h41,0,1,       1,4'b0000,0,0,32'h0,0,0,0);
    tbl[21] = mk(0,0,0,32'h0,0,1,        1,4'b0000,0,0,32'h0,0,0,0);

    rst_i = 1'b1; req_valid_i = 1'b0; req_idx_i = '0; req_data_i = '0;
    req_last_i = 1'b0; out_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk_i);
      rst_i       = tbl[i].rst;
      req_valid_i = tbl[i].v;
      req_idx_i   = tbl[i].idx;
      req_data_i  = tbl[i].data;
      req_last_i  = tbl[i].last;
      out_ready_i = tbl[i].ordy;
      #1;
      chk("req_ready", i, 32'(req_ready_o), 32'(tbl[i].rdy));
      chk("gnt",       i, 32'(gnt_o),       32'(tbl[i].gnt));
      chk("out_valid", i, 32'(out_valid_o), 32'(tbl[i].ov));
      chk("lock",      i, 32'(lock_o),      32'(tbl[i].lock));
      chk("err",       i, 32'(err_o),       32'(tbl[i].err));
      if (tbl[i].ov) begin
        chk("out_idx",  i, 32'(out_idx_o),  32'(tbl[i].oidx));
        chk("out_data", i, out_data_o,      tbl[i].odata);
        chk("out_last", i, 32'(out_last_o), 32'(tbl[i].olast));
      end
    end

    // Back-to-back single beats: one per cycle, each visible the following cycle.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      rst_i = 1'b0; req_valid_i = 1'b1; req_idx_i = 2'(k);
      req_data_i = 32'h50 + 32'(k); req_last_i = 1'b1; out_ready_i = 1'b1;
      #1;
      chk("stream_gnt",   100 + k, 32'(gnt_o),       32'(1) << k);
      chk("stream_ready", 100 + k, 32'(req_ready_o), 32'd1);
      if (k > 0) begin
        chk("stream_valid", 100 + k, 32'(out_valid_o), 32'd1);
        chk("stream_data",  100 + k, out_data_o,       32'h50 + 32'(k - 1));
      end
    end
    @(negedge clk_i);
    req_valid_i = 1'b0;
    #1;
    chk("stream_tail_valid", 104, 32'(out_valid_o), 32'd1);
    chk("stream_tail_data",  104, out_data_o,       32'h53);

    // Single stalled beat released later, waited for with a bounded loop.
    @(negedge clk_i);
    req_valid_i = 1'b1; req_idx_i = 2'd1; req_data_i = 32'h60; req_last_i = 1'b1;
    out_ready_i = 1'b0;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("held_data", 200, out_data_o, 32'h60);
    @(negedge clk_i);
    out_ready_i = 1'b1;
    begin
      int n;
      n = 0;
      #1;
      while (out_valid_o && n < 5) begin
        @(negedge clk_i);
        #1;
        n++;
      end
      chk("drain_bounded", 201, 32'(n < 5), 32'd1);
      chk("drain_cycles",  202, 32'(n),     32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
